int_fu_ctrl: RTL and testbench
==============================

# int_fu_ctrl

Scoreboard-controlled 16-bit integer functional unit that wraps the team's combinational integer operators (AND, OR, XOR, ADD, SUB, NOT) in the four scoreboard phases: issue, read operands, execute and write result. It sits directly downstream of the scoreboard issue/hazard logic and upstream of the register-file write port. It receives an issued instruction, waits for operand readiness (RAW), executes for a fixed latency, then holds the result until the scoreboard grants write-back (WAR).

## Interface
- WIDTH, 16, datapath width in bits.
- REG_W, 4, destination register index width.
- EXEC_LAT, 2, execute-phase cycles; legal range 1..15.

- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  scoreboard issues an instruction to this unit.
- issue_op  in  3  opcode: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB (a-b), 101 NOT a; 110 and 111 produce result 0.
- issue_dest  in  REG_W  destination register index.
- busy  out  1  FU status "Busy" to the scoreboard.
- rd_ok  in  1  both source operands ready (Rj & Rk).
- src_a, src_b  in  WIDTH  register-file operand values, sampled in READ.
- rd_done  out  1  one-cycle pulse: operands read, so the scoreboard clears Rj/Rk.
- wr_req  out  1  result ready and waiting for write-back.
- wr_grant  in  1  no WAR hazard; write permitted.
- wr_dest  out  REG_W  destination index; valid while wr_req=1.
- wr_data  out  WIDTH  result; valid while wr_req=1.
- wr_done  out  1  one-cycle pulse: write-back complete, so the scoreboard releases the FU.

## Operation
- FSM states: IDLE, READ, EXEC, WRITE. All outputs are registered or decoded from the state only; no combinational path from any input to any output.
- IDLE: busy=0.
  - issue_valid=1 at an edge: latch issue_op and issue_dest, go to READ.
  - issue_valid is ignored in every other state.
- READ: busy=1.
  - rd_ok=1 at an edge: capture src_a and src_b, load counter with EXEC_LAT-1, go to EXEC, and assert rd_done for the next cycle only.
  - rd_ok=0: stay in READ indefinitely.
- EXEC: busy=1, counter decrements each edge.
  - Edge with counter=0: register the result into wr_data, drive wr_dest, go to WRITE.
- WRITE: busy=1, wr_req=1; wr_data and wr_dest are held stable.
  - wr_grant=1 at an edge: go to IDLE, assert wr_done for the next cycle only, clear wr_req.
  - wr_grant=0: stay in WRITE.
- Arithmetic: ADD and SUB are modulo 2^WIDTH, with no carry, borrow or overflow output. Logic operations are bitwise. NOT uses src_a only.
- rd_ok outside READ and wr_grant outside WRITE are ignored.

## Timing
- Reset values: state=IDLE, busy=0, rd_done=0, wr_req=0, wr_done=0, wr_dest=0, wr_data=0. Reset has priority over all other inputs.
- Reset mid-operation from any state returns to IDLE on that edge. No wr_done or rd_done is produced for the abandoned instruction.
- Reference sequence with rd_ok and wr_grant tied high, issue at edge t:
  - READ occupies cycle t+1.
  - rd_done is high in cycle t+2.
  - EXEC occupies cycles t+2 .. t+1+EXEC_LAT.
  - wr_req is high in cycle t+2+EXEC_LAT.
  - wr_done is high and busy=0 in cycle t+3+EXEC_LAT.
- Total latency from issue to wr_done is EXEC_LAT+3 cycles. Each cycle of rd_ok or wr_grant low adds exactly one cycle.
- A new issue_valid is accepted in the same cycle that wr_done is high, because busy=0 there. wr_done and the new instruction's READ phase then do not overlap.
- rd_done and wr_done are never high for more than one consecutive cycle per instruction.

## Test plan
- AND, EXEC_LAT=2, a=8, b=6, rd_ok=1, wr_grant=1: wr_data=0 and wr_dest is as issued. wr_req is high exactly 4 cycles after the issue edge and wr_done is high 5 cycles after it.
- ADD 0xFFFF+0x0001 gives 0x0000. SUB 8-6 gives 2. SUB 6-8 gives 0xFFFE. XOR 0xAAAA^0xFFFF gives 0x5555. NOT 0x00FF gives 0xFF00. Opcode 111 gives 0.
- Hold rd_ok low for 3 cycles in READ and change src_a while waiting: the value present on the rd_ok edge is used, and wr_done arrives 3 cycles later than in the reference sequence.
- Hold wr_grant low for 5 cycles: wr_req stays high and wr_data stays constant throughout, then a single wr_done pulse follows.
- Pulse issue_valid with a different opcode and destination while busy: the pulse is ignored and the original result and destination are written.
- Assert rst during EXEC: next cycle all outputs are 0 and no wr_done ever appears. A fresh issue then completes normally. Back-to-back issue in the wr_done cycle completes its second result correctly.

Source files
------------

// File: rtl/int_fu_ctrl.sv
// Scoreboard-controlled integer functional unit: issue, read operands, execute
// for a fixed latency, then hold the result until write-back is granted.
module int_fu_ctrl #(
    parameter int WIDTH    = 16,
    parameter int REG_W    = 4,
    parameter int EXEC_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid_i,
    input  logic [2:0]       issue_op_i,
    input  logic [REG_W-1:0] issue_dest_i,
    output logic             busy_o,
    input  logic             rd_ok_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    output logic             rd_done_o,
    output logic             wr_req_o,
    input  logic             wr_grant_i,
    output logic [REG_W-1:0] wr_dest_o,
    output logic [WIDTH-1:0] wr_data_o,
    output logic             wr_done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_XOR = 3'd2,
        OP_ADD = 3'd3,
        OP_SUB = 3'd4,
        OP_NOT = 3'd5,
        OP_RS6 = 3'd6,
        OP_RS7 = 3'd7
    } op_e;

    // Counter is loaded with EXEC_LAT-1 so that EXEC lasts exactly EXEC_LAT cycles.
    localparam logic [3:0] CNT_INIT = 4'(EXEC_LAT - 1);

    state_e             state_q;
    op_e                op_q;
    logic [REG_W-1:0]   dest_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [3:0]         cnt_q;
    logic               rd_done_q;
    logic               wr_req_q;
    logic               wr_done_q;
    logic [REG_W-1:0]   wr_dest_q;
    logic [WIDTH-1:0]   wr_data_q;
    logic [WIDTH-1:0]   result_d;

    always_comb begin
        result_d = '0;
        case (op_q)
            OP_AND:  result_d = a_q & b_q;
            OP_OR:   result_d = a_q | b_q;
            OP_XOR:  result_d = a_q ^ b_q;
            OP_ADD:  result_d = a_q + b_q;
            OP_SUB:  result_d = a_q - b_q;
            OP_NOT:  result_d = ~a_q;
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= OP_AND;
            dest_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            rd_done_q <= 1'b0;
            wr_req_q  <= 1'b0;
            wr_done_q <= 1'b0;
            wr_dest_q <= '0;
            wr_data_q <= '0;
        end else begin
            rd_done_q <= 1'b0;
            wr_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (issue_valid_i) begin
                        op_q    <= op_e'(issue_op_i);
                        dest_q  <= issue_dest_i;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (rd_ok_i) begin
                        a_q       <= src_a_i;
                        b_q       <= src_b_i;
                        cnt_q     <= CNT_INIT;
                        rd_done_q <= 1'b1;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q == 4'd0) begin
                        wr_data_q <= result_d;
                        wr_dest_q <= dest_q;
                        wr_req_q  <= 1'b1;
                        state_q   <= WRITE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WRITE: begin
                    if (wr_grant_i) begin
                        wr_req_q  <= 1'b0;
                        wr_done_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign rd_done_o = rd_done_q;
    assign wr_req_o  = wr_req_q;
    assign wr_done_o = wr_done_q;
    assign wr_dest_o = wr_dest_q;
    assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_int_fu_ctrl.sv
// Randomized scoreboard bench for int_fu_ctrl: the driver pushes expected results,
// a negedge monitor pops and compares them whenever write-back is requested.
module tb_int_fu_ctrl;

    localparam int WIDTH = 16;
    localparam int REG_W = 4;
    localparam int LAT   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid;
    logic [2:0]       issue_op;
    logic [REG_W-1:0] issue_dest;
    logic             busy;
    logic             rd_ok;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             rd_done;
    logic             wr_req;
    logic             wr_grant;
    logic [REG_W-1:0] wr_dest;
    logic [WIDTH-1:0] wr_data;
    logic             wr_done;

    int testsRun    = 0;
    int testsFailed = 0;
    int doneSeen    = 0;
    int doneExp     = 0;

    typedef struct {
        logic [REG_W-1:0] dest;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t expQ[$];
    exp_t held;
    logic prevReq  = 1'b0;
    logic prevDone = 1'b0;
    logic prevRd   = 1'b0;

    int_fu_ctrl #(.WIDTH(WIDTH), .REG_W(REG_W), .EXEC_LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid_i(issue_valid),
        .issue_op_i   (issue_op),
        .issue_dest_i (issue_dest),
        .busy_o       (busy),
        .rd_ok_i      (rd_ok),
        .src_a_i      (src_a),
        .src_b_i      (src_b),
        .rd_done_o    (rd_done),
        .wr_req_o     (wr_req),
        .wr_grant_i   (wr_grant),
        .wr_dest_o    (wr_dest),
        .wr_data_o    (wr_data),
        .wr_done_o    (wr_done)
    );

    always #5 clk = ~clk;

    // Reference behaviour from the opcode table, using plain integer arithmetic.
    function automatic logic [WIDTH-1:0] refResult(input logic [2:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        int ia = int'(a);
        int ib = int'(b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return WIDTH'((ia + ib) % 65536);
            3'd4:    return WIDTH'((ia - ib + 65536) % 65536);
            3'd5:    return ~a;
            default: return '0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on every new write-back request.
    always @(negedge clk) begin
        if (rst) begin
            prevReq  = 1'b0;
            prevDone = 1'b0;
            prevRd   = 1'b0;
        end else begin
            if (wr_done) begin
                doneSeen++;
                checkOutput("wr_done_single", 32'(prevDone), 32'd0);
            end
            if (rd_done)
                checkOutput("rd_done_single", 32'(prevRd), 32'd0);
            if (wr_req && !prevReq) begin
                if (expQ.size() == 0) begin
                    checkOutput("wr_req_unexpected", 32'(wr_req), 32'd0);
                end else begin
                    held = expQ.pop_front();
                    checkOutput("wr_dest", 32'(wr_dest), 32'(held.dest));
                    checkOutput("wr_data", 32'(wr_data), 32'(held.data));
                end
            end else if (wr_req && prevReq) begin
                checkOutput("wr_dest_hold", 32'(wr_dest), 32'(held.dest));
                checkOutput("wr_data_hold", 32'(wr_data), 32'(held.data));
            end
            prevReq  = wr_req;
            prevDone = wr_done;
            prevRd   = rd_done;
        end
    end

    // Called at #1 after an edge; returns at #1 after the edge that raises wr_done.
    task automatic applyStimulus(input logic [2:0] op, input logic [REG_W-1:0] dest,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input int rdDelay, input int grantDelay, input bit spurious);
        int cyc;
        bit seen;
        issue_valid = 1'b1;
        issue_op    = op;
        issue_dest  = dest;
        src_a       = WIDTH'($urandom);
        src_b       = WIDTH'($urandom);
        rd_ok       = 1'b0;
        wr_grant    = 1'b0;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        issue_op    = 3'($urandom);
        issue_dest  = REG_W'($urandom);
        checkOutput("busy_read", 32'(busy), 32'd1);
        for (int i = 0; i < rdDelay; i++) begin
            rd_ok = 1'b0;
            src_a = WIDTH'($urandom);
            src_b = WIDTH'($urandom);
            @(posedge clk); #1;
            checkOutput("rd_done_wait", 32'(rd_done), 32'd0);
        end
        src_a = a;
        src_b = b;
        rd_ok = 1'b1;
        expQ.push_back('{dest: dest, data: refResult(op, a, b)});
        @(posedge clk); #1;
        rd_ok = 1'b0;
        src_a = WIDTH'($urandom);
        src_b = WIDTH'($urandom);
        checkOutput("rd_done", 32'(rd_done), 32'd1);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            if (spurious && cyc == 0) begin
                issue_valid = 1'b1;
                issue_op    = ~op;
                issue_dest  = ~dest;
            end
            rd_ok    = 1'($urandom);
            wr_grant = 1'($urandom);
            @(posedge clk); #1;
            issue_valid = 1'b0;
            cyc++;
            if (wr_req) seen = 1'b1;
        end
        rd_ok    = 1'b0;
        wr_grant = 1'b0;
        checkOutput("wr_req_latency", seen ? 32'(cyc) : 32'd999, 32'(LAT));
        if (!seen) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            expQ.delete();
            return;
        end
        for (int i = 0; i < grantDelay; i++) begin
            if (spurious && i == 0) begin
                issue_valid = 1'b1;
                issue_op    = ~op;
                issue_dest  = ~dest;
            end
            @(posedge clk); #1;
            issue_valid = 1'b0;
            checkOutput("wr_req_hold", 32'(wr_req), 32'd1);
            checkOutput("wr_done_early", 32'(wr_done), 32'd0);
        end
        wr_grant = 1'b1;
        @(posedge clk); #1;
        wr_grant = 1'b0;
        doneExp++;
        checkOutput("wr_done", 32'(wr_done), 32'd1);
        checkOutput("busy_done", 32'(busy), 32'd0);
        checkOutput("wr_req_cleared", 32'(wr_req), 32'd0);
    endtask

    // Abandons an instruction in EXEC; every output must drop to zero.
    task automatic resetDuringExec();
        issue_valid = 1'b1;
        issue_op    = 3'd3;
        issue_dest  = 4'h9;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        src_a = 16'h1234;
        src_b = 16'h4321;
        rd_ok = 1'b1;
        @(posedge clk); #1;
        rd_ok = 1'b0;
        checkOutput("rst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rd_done", 32'(rd_done), 32'd0);
        checkOutput("rst_wr_req", 32'(wr_req), 32'd0);
        checkOutput("rst_wr_done", 32'(wr_done), 32'd0);
        checkOutput("rst_wr_dest", 32'(wr_dest), 32'd0);
        checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
        repeat (10) begin
            rd_ok    = 1'($urandom);
            wr_grant = 1'($urandom);
            @(posedge clk); #1;
            checkOutput("rst_stays_idle", 32'(busy), 32'd0);
        end
        rd_ok    = 1'b0;
        wr_grant = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        issue_valid = 1'b0;
        issue_op    = '0;
        issue_dest  = '0;
        rd_ok       = 1'b0;
        src_a       = '0;
        src_b       = '0;
        wr_grant    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rd_done", 32'(rd_done), 32'd0);
        checkOutput("reset_wr_req", 32'(wr_req), 32'd0);
        checkOutput("reset_wr_done", 32'(wr_done), 32'd0);
        checkOutput("reset_wr_dest", 32'(wr_dest), 32'd0);
        checkOutput("reset_wr_data", 32'(wr_data), 32'd0);
        rst = 1'b0;

        applyStimulus(3'd0, 4'h3, 16'd8, 16'd6, 0, 0, 1'b0);
        applyStimulus(3'd3, 4'h1, 16'hFFFF, 16'h0001, 0, 0, 1'b0);
        applyStimulus(3'd4, 4'h2, 16'd8, 16'd6, 0, 0, 1'b0);
        applyStimulus(3'd4, 4'h4, 16'd6, 16'd8, 0, 0, 1'b0);
        applyStimulus(3'd2, 4'h5, 16'hAAAA, 16'hFFFF, 0, 0, 1'b0);
        applyStimulus(3'd5, 4'h6, 16'h00FF, 16'h1357, 0, 0, 1'b0);
        applyStimulus(3'd7, 4'h7, 16'hBEEF, 16'hCAFE, 0, 0, 1'b0);
        applyStimulus(3'd1, 4'h8, 16'hF0F0, 16'h0F01, 3, 0, 1'b0);
        applyStimulus(3'd3, 4'hA, 16'h1111, 16'h2222, 0, 5, 1'b0);
        applyStimulus(3'd2, 4'hB, 16'h5A5A, 16'h00FF, 1, 2, 1'b1);

        resetDuringExec();
        applyStimulus(3'd3, 4'hC, 16'h7FFF, 16'h0001, 0, 0, 1'b0);
        applyStimulus(3'd4, 4'hD, 16'h0000, 16'h0001, 0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            applyStimulus(3'($urandom), REG_W'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (5) @(posedge clk);
        #1;
        checkOutput("done_count", 32'(doneSeen), 32'(doneExp));
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
